// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle 8-bit shift/rotate unit, one bit position per clock,
// with a start/busy/done handshake for the processor's control unit.
module seq_shift_unit (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [2:0] OP,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ILLEGAL
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROR = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                sign_q, sign_d;
  logic                bad_op_q, bad_op_d;
  logic [DATA_W-1:0]   result_d;
  logic                busy_d;
  logic                done_d;
  logic                illegal_d;

  // True for the three unused opcodes.
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op != OP_SLL) && (op != OP_SRL) && (op != OP_SRA) &&
           (op != OP_ROR) && (op != OP_ROL);
  endfunction

  // Effective shift count: shifts saturate at the data width, rotates wrap modulo 8.
  function automatic logic [CNT_W-1:0] eff_count(input logic [OP_W-1:0]  op,
                                                 input logic [AMT_W-1:0] amt);
    logic [CNT_W-1:0] n;
    n = '0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: begin
        if (amt >= AMT_W'(DATA_W)) n = CNT_W'(DATA_W);
        else                       n = CNT_W'(amt);
      end
      OP_ROR, OP_ROL: n = CNT_W'(amt[2:0]);
      default:        n = '0;
    endcase
    return n;
  endfunction

  // One-position step of the selected operation.
  function automatic logic [DATA_W-1:0] shift_one(input logic [OP_W-1:0]   op,
                                                  input logic [DATA_W-1:0] val,
                                                  input logic              sign);
    logic [DATA_W-1:0] r;
    r = val;
    case (op)
      OP_SLL:  r = {val[DATA_W-2:0], 1'b0};
      OP_SRL:  r = {1'b0, val[DATA_W-1:1]};
      OP_SRA:  r = {sign, val[DATA_W-1:1]};
      OP_ROR:  r = {val[0], val[DATA_W-1:1]};
      OP_ROL:  r = {val[DATA_W-2:0], val[DATA_W-1]};
      default: r = val;
    endcase
    return r;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    work_d    = work_q;
    op_d      = op_q;
    sign_d    = sign_q;
    bad_op_d  = bad_op_q;
    result_d  = RESULT;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          work_d   = DATA1;
          op_d     = OP;
          sign_d   = DATA1[DATA_W-1];
          bad_op_d = is_illegal(OP);
          count_d  = eff_count(OP, DATA2);
          // A zero count still passes through SHIFT once, giving the
          // one-cycle minimum latency before the completion cycle.
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count_q == '0) begin
          state_d = ST_FINISH;
        end else begin
          work_d  = shift_one(op_q, work_q, sign_q);
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Result and completion flags are loaded on the edge entering FINISH
    // so they are visible for exactly the FINISH cycle.
    if (state_d == ST_FINISH && state_q != ST_FINISH) begin
      result_d  = work_d;
      done_d    = 1'b1;
      illegal_d = bad_op_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any operation silently.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      work_q   <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      bad_op_q <= 1'b0;
      RESULT   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ILLEGAL  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      work_q   <= work_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      bad_op_q <= bad_op_d;
      RESULT   <= result_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      ILLEGAL  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit.
module tb_seq_shift_unit;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [2:0] OP;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;
  logic       ILLEGAL;

  int tests;
  int fails;

  seq_shift_unit dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .OP      (OP),
    .RESULT  (RESULT),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ILLEGAL (ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one operation, scramble inputs after acceptance, optionally pulse START
  // mid-operation, then check latency, result, flags, BUSY width and the fall.
  task automatic run_op(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [2:0] op, input logic [7:0] exp_res,
                        input int exp_lat, input logic exp_ill, input bit poke);
    int c;
    int busy_cnt;
    DATA1 = d1;
    DATA2 = d2;
    OP    = op;
    START = 1'b1;
    step();
    START = 1'b0;
    DATA1 = ~d1;
    DATA2 = 8'hFF;
    OP    = 3'b101;
    check({tag, "_busy_rise"}, 32'(BUSY), 32'd1);
    c = 0;
    busy_cnt = 1;
    while (DONE !== 1'b1 && c < 20) begin
      if (poke && c == 1) START = 1'b1;
      step();
      START = 1'b0;
      c++;
      if (BUSY === 1'b1) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(c), 32'(exp_lat));
    check({tag, "_result"}, 32'(RESULT), 32'(exp_res));
    check({tag, "_illegal"}, 32'(ILLEGAL), 32'(exp_ill));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
    step();
    check({tag, "_done_fall"}, 32'(DONE), 32'd0);
    check({tag, "_illegal_fall"}, 32'(ILLEGAL), 32'd0);
    check({tag, "_busy_fall"}, 32'(BUSY), 32'd0);
    check({tag, "_result_hold"}, 32'(RESULT), 32'(exp_res));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b0;
    START = 1'b0;
    DATA1 = 8'h00;
    DATA2 = 8'h00;
    OP    = 3'b000;

    // Reset state
    #12;
    check("rst_result", 32'(RESULT), 32'h00);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_illegal", 32'(ILLEGAL), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // Main function and boundaries
    run_op("sll3",    8'h0F, 8'd3,   3'b000, 8'h78, 3, 1'b0, 1'b0);
    run_op("sra2",    8'h90, 8'd2,   3'b010, 8'hE4, 2, 1'b0, 1'b0);
    run_op("sra200",  8'h80, 8'd200, 3'b010, 8'hFF, 8, 1'b0, 1'b1);
    run_op("ror11",   8'hA5, 8'd11,  3'b011, 8'hB4, 3, 1'b0, 1'b1);
    run_op("rol1",    8'h81, 8'd1,   3'b100, 8'h03, 1, 1'b0, 1'b0);
    run_op("rol8",    8'h81, 8'd8,   3'b100, 8'h81, 1, 1'b0, 1'b0);
    run_op("sll8",    8'hFF, 8'd8,   3'b000, 8'h00, 8, 1'b0, 1'b0);
    run_op("srl9",    8'hFF, 8'd9,   3'b001, 8'h00, 8, 1'b0, 1'b1);
    run_op("sra8pos", 8'h7F, 8'd8,   3'b010, 8'h00, 8, 1'b0, 1'b0);
    run_op("ill101",  8'hC3, 8'd4,   3'b101, 8'hC3, 1, 1'b1, 1'b0);

    // Zero amount with START held through the SHIFT and DONE cycles
    DATA1 = 8'h5A;
    DATA2 = 8'd0;
    OP    = 3'b001;
    START = 1'b1;
    step();
    DATA1 = 8'hFF;
    DATA2 = 8'd1;
    OP    = 3'b000;
    step();
    check("srl0_done", 32'(DONE), 32'd1);
    check("srl0_result", 32'(RESULT), 32'h5A);
    step();
    check("srl0_drop_done", 32'(DONE), 32'd0);
    check("srl0_drop_busy", 32'(BUSY), 32'd0);
    check("srl0_drop_result", 32'(RESULT), 32'h5A);
    START = 1'b0;
    step();
    check("srl0_idle_busy", 32'(BUSY), 32'd0);
    check("srl0_idle_done", 32'(DONE), 32'd0);
    check("srl0_idle_result", 32'(RESULT), 32'h5A);

    // Illegal op
    run_op("ill111", 8'h3C, 8'd5, 3'b111, 8'h3C, 1, 1'b1, 1'b0);

    // Reset mid-operation, asserted between edges
    DATA1 = 8'hFF;
    DATA2 = 8'd8;
    OP    = 3'b000;
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    step();
    #3;
    RESET = 1'b0;
    #1;
    check("mid_rst_result", 32'(RESULT), 32'h00);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    check("mid_rst_illegal", 32'(ILLEGAL), 32'd0);
    step();
    check("rst_hold_done", 32'(DONE), 32'd0);
    step();
    RESET = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_done", 32'(DONE), 32'd0);
      check("post_rst_busy", 32'(BUSY), 32'd0);
    end
    check("post_rst_result", 32'(RESULT), 32'h00);

    run_op("srl7", 8'h80, 8'd7, 3'b001, 8'h01, 7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
